// File: rtl/axi_xbar_1to2_pkg.sv
// Shared types and constants for the 1-master / 2-slave AXI router.
package axi_xbar_1to2_pkg;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK_DEF = 32'hFFFF_0000;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_xbar_1to2_addr_dec.sv
// Address-to-slave decoder: 0 selects the CLINT window, 1 everything else.
module xbar_addr_dec
    import axi_xbar_1to2_pkg::*;
#(
    parameter logic [31:0] BASE = CLINT_BASE_DEF,
    parameter logic [31:0] MASK = CLINT_MASK_DEF
) (
    input  logic [31:0] i_addr,
    output logic        o_sel
);

    assign o_sel = ((i_addr & MASK) == BASE) ? 1'b0 : 1'b1;

endmodule

// File: rtl/axi_xbar_1to2.sv
// AXI4 1-to-2 router with independent single-outstanding read and write paths.
// Zero added latency: payload fans out to both slaves, only valid/ready are steered.
module axi_xbar_1to2
    import axi_xbar_1to2_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    // master side
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_awaddr,
    input  logic [3:0]  m_awid,
    input  logic [7:0]  m_awlen,
    input  logic [2:0]  m_awsize,
    input  logic [1:0]  m_awburst,
    input  logic        m_wvalid,
    output logic        m_wready,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    input  logic        m_wlast,
    output logic        m_bvalid,
    input  logic        m_bready,
    output logic [1:0]  m_bresp,
    output logic [3:0]  m_bid,
    input  logic        m_arvalid,
    output logic        m_arready,
    input  logic [31:0] m_araddr,
    input  logic [3:0]  m_arid,
    input  logic [7:0]  m_arlen,
    input  logic [2:0]  m_arsize,
    input  logic [1:0]  m_arburst,
    output logic        m_rvalid,
    input  logic        m_rready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rlast,
    output logic [3:0]  m_rid,
    // slave 0 (CLINT)
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_awaddr,
    output logic [3:0]  s0_awid,
    output logic [7:0]  s0_awlen,
    output logic [2:0]  s0_awsize,
    output logic [1:0]  s0_awburst,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wstrb,
    output logic        s0_wlast,
    input  logic        s0_bvalid,
    output logic        s0_bready,
    input  logic [1:0]  s0_bresp,
    input  logic [3:0]  s0_bid,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    output logic [31:0] s0_araddr,
    output logic [3:0]  s0_arid,
    output logic [7:0]  s0_arlen,
    output logic [2:0]  s0_arsize,
    output logic [1:0]  s0_arburst,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rlast,
    input  logic [3:0]  s0_rid,
    // slave 1 (memory / peripheral bus)
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_awaddr,
    output logic [3:0]  s1_awid,
    output logic [7:0]  s1_awlen,
    output logic [2:0]  s1_awsize,
    output logic [1:0]  s1_awburst,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wstrb,
    output logic        s1_wlast,
    input  logic        s1_bvalid,
    output logic        s1_bready,
    input  logic [1:0]  s1_bresp,
    input  logic [3:0]  s1_bid,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    output logic [31:0] s1_araddr,
    output logic [3:0]  s1_arid,
    output logic [7:0]  s1_arlen,
    output logic [2:0]  s1_arsize,
    output logic [1:0]  s1_arburst,
    input  logic        s1_rvalid,
    output logic        s1_rready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rlast,
    input  logic [3:0]  s1_rid
);

    rd_state_t r_rd_state, w_rd_next;
    wr_state_t r_wr_state, w_wr_next;
    logic      r_rsel, r_wsel;
    logic      w_ar_sel, w_aw_sel;

    xbar_addr_dec #(.BASE(CLINT_BASE), .MASK(CLINT_MASK)) u_ar_dec (
        .i_addr (m_araddr),
        .o_sel  (w_ar_sel)
    );

    xbar_addr_dec #(.BASE(CLINT_BASE), .MASK(CLINT_MASK)) u_aw_dec (
        .i_addr (m_awaddr),
        .o_sel  (w_aw_sel)
    );

    // Payload fans out unconditionally; the slaves only act on their gated valids.
    assign s0_araddr  = m_araddr;   assign s1_araddr  = m_araddr;
    assign s0_arid    = m_arid;     assign s1_arid    = m_arid;
    assign s0_arlen   = m_arlen;    assign s1_arlen   = m_arlen;
    assign s0_arsize  = m_arsize;   assign s1_arsize  = m_arsize;
    assign s0_arburst = m_arburst;  assign s1_arburst = m_arburst;
    assign s0_awaddr  = m_awaddr;   assign s1_awaddr  = m_awaddr;
    assign s0_awid    = m_awid;     assign s1_awid    = m_awid;
    assign s0_awlen   = m_awlen;    assign s1_awlen   = m_awlen;
    assign s0_awsize  = m_awsize;   assign s1_awsize  = m_awsize;
    assign s0_awburst = m_awburst;  assign s1_awburst = m_awburst;
    assign s0_wdata   = m_wdata;    assign s1_wdata   = m_wdata;
    assign s0_wstrb   = m_wstrb;    assign s1_wstrb   = m_wstrb;
    assign s0_wlast   = m_wlast;    assign s1_wlast   = m_wlast;

    assign m_rdata = r_rsel ? s1_rdata : s0_rdata;
    assign m_rresp = r_rsel ? s1_rresp : s0_rresp;
    assign m_rlast = r_rsel ? s1_rlast : s0_rlast;
    assign m_rid   = r_rsel ? s1_rid   : s0_rid;
    assign m_bresp = r_wsel ? s1_bresp : s0_bresp;
    assign m_bid   = r_wsel ? s1_bid   : s0_bid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
            r_wr_state <= WR_IDLE;
            r_rsel     <= 1'b1;
            r_wsel     <= 1'b1;
        end else begin
            r_rd_state <= w_rd_next;
            r_wr_state <= w_wr_next;
            if (r_rd_state == RD_IDLE && m_arvalid && m_arready)
                r_rsel <= w_ar_sel;
            if (r_wr_state == WR_IDLE && m_awvalid && m_awready)
                r_wsel <= w_aw_sel;
        end
    end

    // Read path; handshakes are forced off while reset is held.
    always_comb begin
        w_rd_next  = r_rd_state;
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        m_arready  = 1'b0;
        m_rvalid   = 1'b0;
        s0_rready  = 1'b0;
        s1_rready  = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                s0_arvalid = m_arvalid & ~w_ar_sel;
                s1_arvalid = m_arvalid &  w_ar_sel;
                m_arready  = w_ar_sel ? s1_arready : s0_arready;
                if (m_arvalid && m_arready)
                    w_rd_next = RD_DATA;
            end
            RD_DATA: begin
                m_rvalid  = r_rsel ? s1_rvalid : s0_rvalid;
                s0_rready = ~r_rsel & m_rready;
                s1_rready =  r_rsel & m_rready;
                if (m_rvalid && m_rready && m_rlast)
                    w_rd_next = RD_IDLE;
            end
            default: w_rd_next = RD_IDLE;
        endcase
        if (reset) begin
            s0_arvalid = 1'b0;
            s1_arvalid = 1'b0;
            m_arready  = 1'b0;
            m_rvalid   = 1'b0;
            s0_rready  = 1'b0;
            s1_rready  = 1'b0;
        end
    end

    // Write path; B from a slave is invisible outside WR_RESP.
    always_comb begin
        w_wr_next  = r_wr_state;
        s0_awvalid = 1'b0;
        s1_awvalid = 1'b0;
        m_awready  = 1'b0;
        s0_wvalid  = 1'b0;
        s1_wvalid  = 1'b0;
        m_wready   = 1'b0;
        m_bvalid   = 1'b0;
        s0_bready  = 1'b0;
        s1_bready  = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                s0_awvalid = m_awvalid & ~w_aw_sel;
                s1_awvalid = m_awvalid &  w_aw_sel;
                m_awready  = w_aw_sel ? s1_awready : s0_awready;
                if (m_awvalid && m_awready)
                    w_wr_next = WR_DATA;
            end
            WR_DATA: begin
                s0_wvalid = m_wvalid & ~r_wsel;
                s1_wvalid = m_wvalid &  r_wsel;
                m_wready  = r_wsel ? s1_wready : s0_wready;
                if (m_wvalid && m_wready && m_wlast)
                    w_wr_next = WR_RESP;
            end
            WR_RESP: begin
                m_bvalid  = r_wsel ? s1_bvalid : s0_bvalid;
                s0_bready = ~r_wsel & m_bready;
                s1_bready =  r_wsel & m_bready;
                if (m_bvalid && m_bready)
                    w_wr_next = WR_IDLE;
            end
            default: w_wr_next = WR_IDLE;
        endcase
        if (reset) begin
            s0_awvalid = 1'b0;
            s1_awvalid = 1'b0;
            m_awready  = 1'b0;
            s0_wvalid  = 1'b0;
            s1_wvalid  = 1'b0;
            m_wready   = 1'b0;
            m_bvalid   = 1'b0;
            s0_bready  = 1'b0;
            s1_bready  = 1'b0;
        end
    end

endmodule
